// File: rtl/insn_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage: address path type,
// NOP encoding, PC increment and the FILL/RUN fetch state.
package insn_fetch_stage_pkg;

    typedef logic [31:0] insn_addr_t;

    localparam logic [31:0] INSN_NOP     = 32'h0000_0000;
    localparam logic [31:0] PC_INCREMENT = 32'd4;

    typedef enum logic [0:0] {
        FETCH_STATE_FILL = 1'b0,
        FETCH_STATE_RUN  = 1'b1
    } fetch_state_e;

    // Instruction addresses are word aligned; the two low bits are dropped.
    function automatic insn_addr_t word_align(input insn_addr_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/insn_fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls in, instruction-memory port and
// IF/ID outputs toward the decoder.
interface insn_fetch_stage_if;
    import insn_fetch_stage_pkg::*;

    logic       stall;
    logic       redirect;
    insn_addr_t redirectTarget;
    insn_addr_t imemAddr;
    logic [31:0] imemInsn;
    logic [31:0] ifidInsn;
    insn_addr_t ifidPC;
    insn_addr_t ifidPCPlus4;
    logic       ifidValid;

    modport master (
        output stall, redirect, redirectTarget, imemInsn,
        input  imemAddr, ifidInsn, ifidPC, ifidPCPlus4, ifidValid
    );

    modport slave (
        input  stall, redirect, redirectTarget, imemInsn,
        output imemAddr, ifidInsn, ifidPC, ifidPCPlus4, ifidValid
    );

endinterface

// File: rtl/insn_fetch_stage_if_id_register.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
// Bubble clears insn/valid but keeps the previous pc fields.
module if_id_register
    import insn_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] insn_i,
    input  insn_addr_t  pc_i,
    input  insn_addr_t  pc_plus4_i,
    output logic [31:0] insn_o,
    output insn_addr_t  pc_o,
    output insn_addr_t  pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] insn_q, insn_d;
    insn_addr_t  pc_q, pc_d;
    insn_addr_t  pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    // Bubble has priority over load; neither means hold.
    always_comb begin
        insn_d     = insn_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (bubble_i) begin
            insn_d  = INSN_NOP;
            valid_d = 1'b0;
        end else if (load_i) begin
            insn_d     = insn_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Field registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            insn_q     <= INSN_NOP;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + PC_INCREMENT;
            valid_q    <= 1'b0;
        end else begin
            insn_q     <= insn_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign insn_o     = insn_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/insn_fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, FILL/RUN sequencing covering the
// one-cycle memory latency, and the IF/ID register feeding the decoder.
module insn_fetch_stage
    import insn_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    insn_fetch_stage_if.slave    fif
);

    insn_addr_t   pc_q, pc_d;
    fetch_state_e state_q, state_d;
    logic         load_s;
    logic         bubble_s;

    // Next-PC and IF/ID control; pc_q always names the word now on imemInsn.
    always_comb begin
        pc_d     = pc_q + PC_INCREMENT;
        state_d  = state_q;
        load_s   = 1'b0;
        bubble_s = 1'b0;
        if (fif.redirect) begin
            pc_d     = word_align(fif.redirectTarget);
            state_d  = FETCH_STATE_RUN;
            bubble_s = 1'b1;
        end else if (state_q == FETCH_STATE_FILL) begin
            pc_d     = pc_q;
            state_d  = FETCH_STATE_RUN;
            bubble_s = 1'b1;
        end else if (fif.stall) begin
            pc_d = pc_q;
        end else begin
            load_s = 1'b1;
        end
    end

    // PC and fetch-state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= FETCH_STATE_FILL;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign fif.imemAddr = pc_d;

    if_id_register #(
        .RESET_PC (RESET_PC)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_s),
        .bubble_i   (bubble_s),
        .insn_i     (fif.imemInsn),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_q + PC_INCREMENT),
        .insn_o     (fif.ifidInsn),
        .pc_o       (fif.ifidPC),
        .pc_plus4_o (fif.ifidPCPlus4),
        .valid_o    (fif.ifidValid)
    );

endmodule

// File: tb/tb_insn_fetch_stage.sv
// Directed bench for insn_fetch_stage: fill, stall, redirect, redirect+stall,
// PC wrap (second instance) and asynchronous mid-stream reset.
module tb_insn_fetch_stage;

    logic clk;
    logic rst;
    int   nvec;
    int   nfail;

    insn_fetch_stage_if mif ();
    insn_fetch_stage_if wif ();

    insn_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .fif (mif.slave)
    );

    insn_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .fif (wif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: word n holds n+1.
    always @(posedge clk) begin
        mif.imemInsn <= {2'b00, mif.imemAddr[31:2]} + 32'd1;
        wif.imemInsn <= {2'b00, wif.imemAddr[31:2]} + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        rst   = 1'b1;
        mif.stall = 1'b0; mif.redirect = 1'b0; mif.redirectTarget = 32'h0;
        wif.stall = 1'b0; wif.redirect = 1'b0; wif.redirectTarget = 32'h0;
        mif.imemInsn = 32'h0;
        wif.imemInsn = 32'h0;

        #3;
        check("rst_insn",   mif.ifidInsn,    32'h0);
        check("rst_pc",     mif.ifidPC,      32'h0);
        check("rst_pc4",    mif.ifidPCPlus4, 32'h4);
        check("rst_valid",  {31'h0, mif.ifidValid}, 32'h0);
        check("rst_addr",   mif.imemAddr,    32'h0);
        check("rst_waddr",  wif.imemAddr,    32'hFFFF_FFF8);
        check("rst_wpc4",   wif.ifidPCPlus4, 32'hFFFF_FFFC);

        cyc(); cyc();
        rst = 1'b0;
        #1;
        // cycle 0
        check("c0_addr",  mif.imemAddr, 32'h0);
        check("c0_valid", {31'h0, mif.ifidValid}, 32'h0);
        cyc();
        check("c1_addr",  mif.imemAddr, 32'h4);
        check("c1_valid", {31'h0, mif.ifidValid}, 32'h0);
        check("c1_waddr", wif.imemAddr, 32'hFFFF_FFFC);
        cyc();
        check("c2_insn",  mif.ifidInsn, 32'h1);
        check("c2_pc",    mif.ifidPC,   32'h0);
        check("c2_pc4",   mif.ifidPCPlus4, 32'h4);
        check("c2_valid", {31'h0, mif.ifidValid}, 32'h1);
        check("c2_wpc",   wif.ifidPC,   32'hFFFF_FFF8);
        cyc();
        check("c3_insn",  mif.ifidInsn, 32'h2);
        check("c3_pc",    mif.ifidPC,   32'h4);
        check("c3_wpc",   wif.ifidPC,   32'hFFFF_FFFC);
        check("c3_wpc4",  wif.ifidPCPlus4, 32'h0);
        cyc();
        mif.stall = 1'b1;
        #1;
        check("st0_insn", mif.ifidInsn, 32'h3);
        check("st0_pc",   mif.ifidPC,   32'h8);
        check("st0_addr", mif.imemAddr, 32'hC);
        check("c4_wpc",   wif.ifidPC,   32'h0);
        cyc();
        check("st1_insn", mif.ifidInsn, 32'h3);
        check("st1_pc",   mif.ifidPC,   32'h8);
        check("st1_addr", mif.imemAddr, 32'hC);
        check("c5_wpc",   wif.ifidPC,   32'h4);
        cyc();
        check("st2_pc",   mif.ifidPC,   32'h8);
        check("st2_addr", mif.imemAddr, 32'hC);
        cyc();
        mif.stall = 1'b0;
        #1;
        check("st3_pc",    mif.ifidPC,   32'h8);
        check("st3_valid", {31'h0, mif.ifidValid}, 32'h1);
        check("st3_addr",  mif.imemAddr, 32'h10);
        cyc();
        check("rel_insn", mif.ifidInsn, 32'h4);
        check("rel_pc",   mif.ifidPC,   32'hC);
        cyc();
        check("rel2_insn", mif.ifidInsn, 32'h5);
        check("rel2_pc",   mif.ifidPC,   32'h10);

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("ar_insn",  mif.ifidInsn,    32'h0);
        check("ar_valid", {31'h0, mif.ifidValid}, 32'h0);
        check("ar_pc",    mif.ifidPC,      32'h0);
        check("ar_pc4",   mif.ifidPCPlus4, 32'h4);
        check("ar_addr",  mif.imemAddr,    32'h0);
        cyc();
        rst = 1'b0;
        #1;
        check("r0_addr", mif.imemAddr, 32'h0);
        cyc();
        check("r1_addr",  mif.imemAddr, 32'h4);
        check("r1_valid", {31'h0, mif.ifidValid}, 32'h0);
        cyc();
        check("r2_insn", mif.ifidInsn, 32'h1);
        check("r2_pc",   mif.ifidPC,   32'h0);
        cyc();
        check("r3_pc",   mif.ifidPC,   32'h4);
        cyc();
        mif.redirect = 1'b1;
        mif.redirectTarget = 32'h0000_0040;
        #1;
        check("rd_pc",   mif.ifidPC,   32'h8);
        check("rd_addr", mif.imemAddr, 32'h40);
        cyc();
        mif.redirect = 1'b0;
        #1;
        check("rd1_valid", {31'h0, mif.ifidValid}, 32'h0);
        check("rd1_insn",  mif.ifidInsn, 32'h0);
        check("rd1_pc",    mif.ifidPC,   32'h8);
        check("rd1_addr",  mif.imemAddr, 32'h44);
        cyc();
        check("rd2_pc",    mif.ifidPC,   32'h40);
        check("rd2_insn",  mif.ifidInsn, 32'h11);
        check("rd2_valid", {31'h0, mif.ifidValid}, 32'h1);
        mif.redirect = 1'b1;
        mif.stall    = 1'b1;
        mif.redirectTarget = 32'h0000_0083;
        #1;
        check("rs_addr", mif.imemAddr, 32'h80);
        cyc();
        mif.redirect = 1'b0;
        mif.stall    = 1'b0;
        #1;
        check("rs1_valid", {31'h0, mif.ifidValid}, 32'h0);
        check("rs1_insn",  mif.ifidInsn, 32'h0);
        cyc();
        check("rs2_pc",    mif.ifidPC,   32'h80);
        check("rs2_insn",  mif.ifidInsn, 32'h21);
        check("rs2_valid", {31'h0, mif.ifidValid}, 32'h1);
        cyc();
        check("rs3_pc",    mif.ifidPC,   32'h84);
        check("rs3_pc4",   mif.ifidPCPlus4, 32'h88);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
